// File: rtl/hazard_detection_unit_pkg.sv
// Shared definitions for the load-use hazard detection unit and the
// pipeline control wiring around it.
package hazard_detection_unit_pkg;

  // Register-file address width (x0..x31).
  localparam int REG_ADDR_W = 5;

  // Default width of the stall-cycle performance counter.
  localparam int STALL_CNT_W = 32;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  // Pipeline control bundle produced by the hazard unit.
  typedef struct packed {
    logic pc_we;       // 1 = PC may update
    logic ifid_we;     // 1 = IF/ID may update
    logic idex_flush;  // 1 = load a bubble into ID/EX
  } hazard_ctrl_t;

endpackage

// File: rtl/hazard_detection_unit_cmp.sv
// Load-use comparator: flags when the load in EX writes a register that the
// instruction in ID reads. Kept separate so the forwarding logic can reuse it.
module hazard_detection_unit_cmp
  import hazard_detection_unit_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              mem_read,
  output logic              hazard
);

  logic rd_nonzero;
  logic src_match;

  // Purely combinational compare; the source-use of rs1/rs2 is not checked,
  // so the result is a conservative stall request.
  always_comb begin
    rd_nonzero = (rd != ADDR_W'(REG_X0));
    src_match  = (rd == rs1) || (rd == rs2);
    hazard     = mem_read && rd_nonzero && src_match;
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detection for the 5-stage pipeline. The stall controls are
// combinational from the ID/EX address inputs only; a small clocked block
// keeps a one-cycle-delayed copy of the hazard and a stall-cycle counter.
module hazard_detection_unit #(
  parameter int REG_ADDR_W  = hazard_detection_unit_pkg::REG_ADDR_W,
  parameter int STALL_CNT_W = hazard_detection_unit_pkg::STALL_CNT_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [REG_ADDR_W-1:0]  ID_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0]  ID_rs2_addr_i,
  input  logic [REG_ADDR_W-1:0]  EX_rd_addr_i,
  input  logic                   EX_MemRead_i,
  output logic                   PCWrite_en_o,
  output logic                   IF_ID_write_en_o,
  output logic                   ID_EX_flush_o,
  output logic                   stall_prev_o,
  output logic [STALL_CNT_W-1:0] stall_count_o
);

  import hazard_detection_unit_pkg::hazard_ctrl_t;

  logic         hazard;
  hazard_ctrl_t ctrl;

  hazard_detection_unit_cmp #(
    .ADDR_W (REG_ADDR_W)
  ) u_cmp (
    .rd       (EX_rd_addr_i),
    .rs1      (ID_rs1_addr_i),
    .rs2      (ID_rs2_addr_i),
    .mem_read (EX_MemRead_i),
    .hazard   (hazard)
  );

  // Freeze PC and IF/ID and bubble ID/EX while the hazard is present; no
  // clock or reset involvement so the controls are valid with the clock idle.
  always_comb begin
    ctrl.pc_we      = 1'b1;
    ctrl.ifid_we    = 1'b1;
    ctrl.idex_flush = 1'b0;
    if (hazard) begin
      ctrl.pc_we      = 1'b0;
      ctrl.ifid_we    = 1'b0;
      ctrl.idex_flush = 1'b1;
    end
  end

  assign PCWrite_en_o     = ctrl.pc_we;
  assign IF_ID_write_en_o = ctrl.ifid_we;
  assign ID_EX_flush_o    = ctrl.idex_flush;

  // Performance monitor: delayed hazard flag and wrapping stall-cycle count;
  // reset wins over an increment in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_prev_o  <= 1'b0;
      stall_count_o <= '0;
    end else begin
      stall_prev_o <= hazard;
      if (hazard) begin
        stall_count_o <= stall_count_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: a vector table applied with the clock idle,
// a hand-written clocked reset/stall sequence, and randomized cycles checked
// against a behavioural model of the stall rules.
module tb_hazard_detection_unit;

  localparam int AW = 5;
  localparam int CW = 32;

  logic          clk_i;
  logic          rst_i;
  logic [AW-1:0] ID_rs1_addr_i;
  logic [AW-1:0] ID_rs2_addr_i;
  logic [AW-1:0] EX_rd_addr_i;
  logic          EX_MemRead_i;
  logic          PCWrite_en_o;
  logic          IF_ID_write_en_o;
  logic          ID_EX_flush_o;
  logic          stall_prev_o;
  logic [CW-1:0] stall_count_o;

  hazard_detection_unit #(
    .REG_ADDR_W  (AW),
    .STALL_CNT_W (CW)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .ID_rs1_addr_i    (ID_rs1_addr_i),
    .ID_rs2_addr_i    (ID_rs2_addr_i),
    .EX_rd_addr_i     (EX_rd_addr_i),
    .EX_MemRead_i     (EX_MemRead_i),
    .PCWrite_en_o     (PCWrite_en_o),
    .IF_ID_write_en_o (IF_ID_write_en_o),
    .ID_EX_flush_o    (ID_EX_flush_o),
    .stall_prev_o     (stall_prev_o),
    .stall_count_o    (stall_count_o)
  );

  // ---------------- clock / reset ----------------
  logic clk_run;
  initial begin
    clk_i   = 1'b0;
    clk_run = 1'b0;
  end
  always #5 if (clk_run) clk_i = ~clk_i;

  // ---------------- scoreboard ----------------
  int checks;
  int failures;
  logic [CW-1:0] exp_q[$];

  // Behavioural model state.
  int unsigned   m_count;
  logic          m_prev;

  task automatic check_val(input string name, input logic [CW-1:0] act,
                           input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Stall rule stated directly: a load whose destination is a real register
  // (not x0) stalls if that register appears among the ID sources.
  function automatic logic model_stall(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                       input logic [AW-1:0] rd, input logic mr);
    logic [AW-1:0] srcs[2];
    logic used;
    srcs[0] = rs1;
    srcs[1] = rs2;
    used = 1'b0;
    foreach (srcs[k]) if (srcs[k] == rd) used = 1'b1;
    return mr && (rd != 0) && used;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic mr);
    ID_rs1_addr_i = rs1;
    ID_rs2_addr_i = rs2;
    EX_rd_addr_i  = rd;
    EX_MemRead_i  = mr;
  endtask

  task automatic check_comb(input string tag, input logic hz);
    check_val({tag, ".pc_we"},   {31'd0, PCWrite_en_o},     {31'd0, ~hz});
    check_val({tag, ".ifid_we"}, {31'd0, IF_ID_write_en_o}, {31'd0, ~hz});
    check_val({tag, ".flush"},   {31'd0, ID_EX_flush_o},    {31'd0, hz});
  endtask

  // One clock cycle: inputs applied after the falling edge, combinational
  // outputs checked before the rising edge, registers checked 1 ns after it.
  task automatic cycle(input string tag, input logic rst,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic mr);
    logic hz;
    @(negedge clk_i);
    rst_i = rst;
    drive(rs1, rs2, rd, mr);
    hz = model_stall(rs1, rs2, rd, mr);
    #1;
    check_comb(tag, hz);
    if (rst) begin
      m_count = 0;
      m_prev  = 1'b0;
    end else begin
      m_prev  = hz;
      m_count = m_count + (hz ? 1 : 0);
    end
    exp_q.push_back(CW'(m_count));
    @(posedge clk_i);
    #1;
    check_val({tag, ".stall_count"}, stall_count_o, exp_q.pop_front());
    check_val({tag, ".stall_prev"}, {31'd0, stall_prev_o}, {31'd0, m_prev});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic          mr;
    logic          pc_we;
    logic          ifid_we;
    logic          flush;
  } vec_t;

  vec_t vecs[8];

  initial begin
    checks   = 0;
    failures = 0;
    m_count  = 0;
    m_prev   = 1'b0;
    rst_i    = 1'b0;
    drive('0, '0, '0, 1'b0);

    vecs[0] = '{rs1: 5'd1, rs2: 5'd2, rd: 5'd3, mr: 1'b0, pc_we: 1'b1, ifid_we: 1'b1, flush: 1'b0};
    vecs[1] = '{rs1: 5'd1, rs2: 5'd2, rd: 5'd0, mr: 1'b1, pc_we: 1'b1, ifid_we: 1'b1, flush: 1'b0};
    vecs[2] = '{rs1: 5'd0, rs2: 5'd2, rd: 5'd0, mr: 1'b1, pc_we: 1'b1, ifid_we: 1'b1, flush: 1'b0};
    vecs[3] = '{rs1: 5'd1, rs2: 5'd2, rd: 5'd3, mr: 1'b1, pc_we: 1'b1, ifid_we: 1'b1, flush: 1'b0};
    vecs[4] = '{rs1: 5'd5, rs2: 5'd2, rd: 5'd5, mr: 1'b1, pc_we: 1'b0, ifid_we: 1'b0, flush: 1'b1};
    vecs[5] = '{rs1: 5'd1, rs2: 5'd5, rd: 5'd5, mr: 1'b1, pc_we: 1'b0, ifid_we: 1'b0, flush: 1'b1};
    vecs[6] = '{rs1: 5'd5, rs2: 5'd5, rd: 5'd5, mr: 1'b1, pc_we: 1'b0, ifid_we: 1'b0, flush: 1'b1};
    vecs[7] = '{rs1: 5'd31, rs2: 5'd0, rd: 5'd31, mr: 1'b0, pc_we: 1'b1, ifid_we: 1'b1, flush: 1'b0};

    // Clock held idle: outputs must follow inputs within 1 ns.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mr);
      #1;
      check_val($sformatf("vec%0d.pc_we", i),   {31'd0, PCWrite_en_o},     {31'd0, vecs[i].pc_we});
      check_val($sformatf("vec%0d.ifid_we", i), {31'd0, IF_ID_write_en_o}, {31'd0, vecs[i].ifid_we});
      check_val($sformatf("vec%0d.flush", i),   {31'd0, ID_EX_flush_o},    {31'd0, vecs[i].flush});
      #4;
    end

    // Clocked sequence: reset for 2 edges, 3 stalls, 2 clean, reset mid-stall.
    clk_run = 1'b1;
    cycle("rst0", 1'b1, 5'd1, 5'd2, 5'd3, 1'b0);
    cycle("rst1", 1'b1, 5'd1, 5'd2, 5'd3, 1'b0);
    cycle("hz0",  1'b0, 5'd7, 5'd2, 5'd7, 1'b1);
    cycle("hz1",  1'b0, 5'd1, 5'd7, 5'd7, 1'b1);
    cycle("hz2",  1'b0, 5'd7, 5'd7, 5'd7, 1'b1);
    cycle("cl0",  1'b0, 5'd1, 5'd2, 5'd7, 1'b0);
    cycle("cl1",  1'b0, 5'd1, 5'd2, 5'd3, 1'b1);
    cycle("rsthz", 1'b1, 5'd9, 5'd2, 5'd9, 1'b1);
    cycle("post", 1'b0, 5'd4, 5'd2, 5'd4, 1'b1);

    // Randomized cycles with a narrow address range to get frequent hits.
    for (int n = 0; n < 300; n++) begin
      cycle("rnd", ($urandom_range(0, 24) == 0),
            AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
            AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    clk_run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
Detects load-use data hazards in the 5-stage RISC-V pipeline. It compares the ID-stage source registers against the destination register of a load currently in EX. On a hazard it freezes the PC and the IF/ID register and inserts a bubble by flushing ID/EX. The hazard decision is purely combinational. A small clocked block alongside it counts stall cycles for performance monitoring.

Parameters:
- REG_ADDR_W, 5, register-file address width (x0..x31)
- STALL_CNT_W, 32, width of the stall-cycle counter

Ports:
- clk_i  input  1  system clock; all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- ID_rs1_addr_i  input  REG_ADDR_W  rs1 of the instruction in ID
- ID_rs2_addr_i  input  REG_ADDR_W  rs2 of the instruction in ID
- EX_rd_addr_i  input  REG_ADDR_W  rd of the instruction in EX
- EX_MemRead_i  input  1  instruction in EX is a load
- PCWrite_en_o  output  1  1 = PC may update; 0 = hold PC
- IF_ID_write_en_o  output  1  1 = IF/ID may update; 0 = hold
- ID_EX_flush_o  output  1  1 = load a bubble (NOP/zero control) into ID/EX
- stall_prev_o  output  1  registered copy of the last cycle's hazard
- stall_count_o  output  STALL_CNT_W  total number of stall cycles since reset

Behaviour:
- Internal signal: hazard = EX_MemRead_i AND (EX_rd_addr_i != 0) AND ((EX_rd_addr_i == ID_rs1_addr_i) OR (EX_rd_addr_i == ID_rs2_addr_i)).
- Outputs driven from the hazard signal:
  - PCWrite_en_o = ~hazard
  - IF_ID_write_en_o = ~hazard
  - ID_EX_flush_o = hazard
- These three outputs are combinational, with zero-cycle latency.
- They depend only on the four address/MemRead inputs. They must not depend on clk_i, rst_i or any register, so they are correct even when the clock is idle or undriven.
- rd = x0 never causes a stall, even when rs1 or rs2 is also x0.
- A match on rs1 only, rs2 only, or both gives the same single stall response.
- No check is made on whether the ID instruction actually uses rs1/rs2. The pipeline accepts a conservative stall.
- With no hazard the defaults are PCWrite_en_o=1, IF_ID_write_en_o=1, ID_EX_flush_o=0.
- Stall duration: exactly 1 cycle per load-use pair. After the bubble the load has moved to MEM, so EX_MemRead_i clears and the hazard deasserts without extra logic.
- Sequential part (rising edge of clk_i):
  - rst_i=1: stall_prev_o<=0 and stall_count_o<=0. This overrides any increment in the same cycle.
  - Otherwise: stall_prev_o<=hazard.
  - Otherwise: stall_count_o<=stall_count_o+1 when hazard=1. It wraps modulo 2^STALL_CNT_W and saturation is not used.
- Reset asserted mid-stall clears only the counters. The combinational outputs still follow their inputs.

Decomposition:
- Shared package defines:
  - REG_ADDR_W=5
  - the constant for x0 (5'd0)
  - a packed struct hazard_ctrl_t {pc_we, ifid_we, idex_flush} for the top-level pipeline wiring.
- Module layout:
  - The unit itself is a single module: one combinational compare block plus one always_ff counter block.
  - No sub-module is required.
  - Optional: factor the compare into load_use_cmp (rd, rs1, rs2, memread -> hazard) if the forwarding unit reuses it.

Test Plan:
- rs1=1, rs2=2, rd=3, MemRead=0 -> PCWrite=1, IF_ID_we=1, flush=0.
- rs1=1, rs2=2, rd=0, MemRead=1 -> 1,1,0 (x0 never stalls). Repeat with rs1=0, rd=0, MemRead=1 -> 1,1,0.
- rs1=1, rs2=2, rd=3, MemRead=1 -> 1,1,0 (no address match).
- Each of the following -> 0,0,1:
  - rs1=5, rs2=2, rd=5, MemRead=1
  - rs1=1, rs2=5, rd=5, MemRead=1
  - rs1=5, rs2=5, rd=5, MemRead=1
- Apply the outputs check 1 ns after input change with clk_i held idle -> values above hold (purely combinational).
- Clocked sequence:
  - Stimulus: rst_i=1 for 2 edges, then 3 hazard cycles, 2 clean cycles, then rst_i=1 during a hazard cycle.
  - Required response: stall_count_o = 0, then 3, held at 3, then 0. stall_prev_o tracks the hazard delayed by one cycle and clears on reset.
